dsp_be_bist_tx: RTL and testbench

//  On-chip BIST stimulus source for the backend equalizer. Each cycle it generates PRLL_RANK PRBS bits and

---
 rtl/dsp_be_bist_tx_if.sv | 19 +
 rtl/dsp_be_bist_tx.sv | 214 +++++++++++++++++++++
 tb/tb_dsp_be_bist_tx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_be_bist_tx_if.sv
// ---------------------------------------------------------------------------
// dsp_be_bist_tx_if
// Output bus of the BIST stimulus source, in the same shape as the ADC
// backend data bus so it can feed the i_dat_be mux directly.
//   o_dat      : PRLL_RANK x 6-bit signed samples, lane k at [6k+5:6k]
//   o_bits_ref : transmitted bits aligned with o_dat (lane 0 = earliest)
//   o_vld      : o_dat / o_bits_ref valid
// Modports: master (source side, drives), slave (consumer side).
// ---------------------------------------------------------------------------
interface dsp_be_bist_tx_if #(
   parameter int unsigned PRLL_RANK = 64
);
   logic [PRLL_RANK*6-1:0] o_dat;
   logic [PRLL_RANK-1:0]   o_bits_ref;
   logic                   o_vld;

   modport master (output o_dat, o_bits_ref, o_vld);
   modport slave  (input  o_dat, o_bits_ref, o_vld);
endinterface

// File: rtl/dsp_be_bist_tx.sv
// ---------------------------------------------------------------------------
// dsp_be_bist_tx
// On-chip BIST stimulus source for the backend equalizer. Generates
// PRLL_RANK PRBS (or fixed-pattern) bits per enabled cycle, maps them to
// +1/-1 symbols, applies a 3-tap ISI channel (hm1/h0/hp1) and emits
// saturated 6-bit samples plus the time-aligned reference bits.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_en                  advance enable (0 freezes all state)
//   i_start / i_stop      start (IDLE only) / return to IDLE
//   i_cfg_mode            0 PRBS7, 1 PRBS15, 2 PRBS31, 3 fixed pattern
//   i_cfg_seed, i_cfg_pat LFSR seed, fixed pattern word
//   i_cfg_h0/hm1/hp1      signed 6-bit channel taps
//   i_err_inj             error-inject request
//   be (master)           o_dat / o_bits_ref / o_vld
//   o_busy, o_word_cnt    state != IDLE, saturating valid-word count
// Build option: define DSP_BE_BIST_TX_ERR_INJ_EN to enable error injection
// (a rising edge of i_err_inj in RUN inverts lane 0's symbol of the next
// emitted word). Without it i_err_inj is ignored.
// ---------------------------------------------------------------------------
module dsp_be_bist_tx #(
   parameter int unsigned PRLL_RANK = 64,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [1:0]           i_cfg_mode,
   input  logic [30:0]          i_cfg_seed,
   input  logic [PRLL_RANK-1:0] i_cfg_pat,
   input  logic [5:0]           i_cfg_h0,
   input  logic [5:0]           i_cfg_hm1,
   input  logic [5:0]           i_cfg_hp1,
   input  logic                 i_err_inj,
   dsp_be_bist_tx_if.master     be,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_word_cnt
);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
   localparam int unsigned DW = PRLL_RANK * 6;

   state_t               state_q, state_d;
   logic                 fill_q, fill_d;
   logic [30:0]          lfsr_q, lfsr_d;
   logic [PRLL_RANK-1:0] r_nxt_q, r_nxt_d, r_cur_q, r_cur_d;
   logic                 r_prv_q, r_prv_d;
   logic [DW-1:0]        dat_q, dat_d;
   logic [PRLL_RANK-1:0] bits_q, bits_d;
   logic                 vld_q, vld_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [30:0]          seed_mask, seed_ld, lfsr_step;
   logic                 fb;
   logic [PRLL_RANK-1:0] prbs_word, sym_bits;
   logic [PRLL_RANK+1:0] sym_ext;
   logic signed [7:0]    sum;
   logic [DW-1:0]        y_word;
   logic                 inj;

`ifdef DSP_BE_BIST_TX_ERR_INJ_EN
   logic err_q;
   always_ff @(posedge i_clk) begin
      if (i_rst)     err_q <= 1'b0;
      else if (i_en) err_q <= i_err_inj;
   end
   assign inj = (state_q == RUN) && i_err_inj && !err_q;
`else
   logic unused_err_inj;
   assign unused_err_inj = i_err_inj;
   assign inj            = 1'b0;
`endif

   function automatic logic signed [7:0] tap_term(input logic [5:0] h, input logic b);
      logic signed [7:0] hx;
      hx = {{2{h[5]}}, h};
      return b ? hx : -hx;
   endfunction

   // Seed load mask also keeps the shifted LFSR confined to ORDER bits.
   always_comb begin
      case (i_cfg_mode)
         2'd0:    seed_mask = 31'h0000_007F;
         2'd1:    seed_mask = 31'h0000_7FFF;
         default: seed_mask = '1;
      endcase
      seed_ld = i_cfg_seed & seed_mask;
      if (seed_ld == '0) seed_ld = 31'd1;
   end

   // PRLL_RANK serial Fibonacci steps unrolled; the new bit is the output bit.
   always_comb begin
      lfsr_step = lfsr_q;
      fb        = 1'b0;
      prbs_word = '0;
      for (int unsigned i = 0; i < PRLL_RANK; i++) begin
         case (i_cfg_mode)
            2'd0:    fb = lfsr_step[6]  ^ lfsr_step[5];
            2'd1:    fb = lfsr_step[14] ^ lfsr_step[13];
            default: fb = lfsr_step[30] ^ lfsr_step[27];
         endcase
         lfsr_step    = {lfsr_step[29:0], fb} & seed_mask;
         prbs_word[i] = fb;
      end
   end

   // sym_ext = {next word lane 0, current word, previous word last lane}, so
   // lane k sees prev/cur/next at sym_ext[k], [k+1], [k+2].
   always_comb begin
      sym_bits    = r_cur_q;
      sym_bits[0] = r_cur_q[0] ^ inj;
      sym_ext     = {r_nxt_q[0], sym_bits, r_prv_q};
      sum         = '0;
      y_word      = '0;
      for (int unsigned k = 0; k < PRLL_RANK; k++) begin
         sum = tap_term(i_cfg_h0,  sym_ext[k+1])
             + tap_term(i_cfg_hm1, sym_ext[k+2])
             + tap_term(i_cfg_hp1, sym_ext[k]);
         if (sum > 8'sd31)       y_word[k*6 +: 6] = 6'h1F;
         else if (sum < -8'sd32) y_word[k*6 +: 6] = 6'h20;
         else                    y_word[k*6 +: 6] = sum[5:0];
      end
   end

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      lfsr_d  = lfsr_q;
      r_nxt_d = r_nxt_q;
      r_cur_d = r_cur_q;
      r_prv_d = r_prv_q;
      dat_d   = dat_q;
      bits_d  = bits_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      if (i_en) begin
         case (state_q)
            IDLE: begin
               // Pipeline cleared here so the first word sees r_prv = 0.
               lfsr_d  = seed_ld;
               r_nxt_d = '0;
               r_cur_d = '0;
               r_prv_d = 1'b0;
               fill_d  = 1'b0;
               vld_d   = 1'b0;
               if (i_start && !i_stop) begin
                  state_d = FILL;
                  cnt_d   = '0;
               end
            end
            FILL, RUN: begin
               if (i_stop) begin
                  state_d = IDLE;
                  vld_d   = 1'b0;
               end else begin
                  if (i_cfg_mode == 2'd3) begin
                     r_nxt_d = i_cfg_pat;
                  end else begin
                     lfsr_d  = lfsr_step;
                     r_nxt_d = prbs_word;
                  end
                  r_cur_d = r_nxt_q;
                  r_prv_d = r_cur_q[PRLL_RANK-1];
                  if (state_q == FILL) begin
                     fill_d = 1'b1;
                     if (fill_q) state_d = RUN;
                  end else begin
                     dat_d  = y_word;
                     bits_d = r_cur_q;
                     vld_d  = 1'b1;
                     if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         fill_q  <= 1'b0;
         lfsr_q  <= '0;
         r_nxt_q <= '0;
         r_cur_q <= '0;
         r_prv_q <= 1'b0;
         dat_q   <= '0;
         bits_q  <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         lfsr_q  <= lfsr_d;
         r_nxt_q <= r_nxt_d;
         r_cur_q <= r_cur_d;
         r_prv_q <= r_prv_d;
         dat_q   <= dat_d;
         bits_q  <= bits_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

   assign be.o_dat      = dat_q;
   assign be.o_bits_ref = bits_q;
   assign be.o_vld      = vld_q;
   assign o_busy        = (state_q != IDLE);
   assign o_word_cnt    = cnt_q;

endmodule

// File: tb/tb_dsp_be_bist_tx.sv
module tb_dsp_be_bist_tx;
   localparam int unsigned P  = 64;
   localparam int unsigned CW = 4;
`ifdef DSP_BE_BIST_TX_ERR_INJ_EN
   localparam bit INJ = 1'b1;
`else
   localparam bit INJ = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, en, start, stop, err_inj;
   logic [1:0]    mode;
   logic [30:0]   seed;
   logic [P-1:0]  pat;
   logic [5:0]    h0, hm1, hp1;
   logic          busy;
   logic [CW-1:0] wcnt;
   int            checks = 0;
   int            errors = 0;

   dsp_be_bist_tx_if #(.PRLL_RANK(P)) be_if ();

   dsp_be_bist_tx #(.PRLL_RANK(P), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start), .i_stop(stop),
      .i_cfg_mode(mode), .i_cfg_seed(seed), .i_cfg_pat(pat),
      .i_cfg_h0(h0), .i_cfg_hm1(hm1), .i_cfg_hp1(hp1), .i_err_inj(err_inj),
      .be(be_if.master), .o_busy(busy), .o_word_cnt(wcnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   logic [30:0]  m_lfsr;
   logic [P-1:0] m_cur, m_nxt;
   logic         m_prv;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_gen(output logic [P-1:0] w);
      logic fbit;
      w = '0;
      for (int i = 0; i < P; i++) begin
         if (mode == 2'd0)      fbit = m_lfsr[6]  ^ m_lfsr[5];
         else if (mode == 2'd1) fbit = m_lfsr[14] ^ m_lfsr[13];
         else                   fbit = m_lfsr[30] ^ m_lfsr[27];
         m_lfsr = {m_lfsr[29:0], fbit};
         w[i]   = fbit;
      end
      if (mode == 2'd3) w = pat;
   endtask

   task automatic m_start();
      if (mode == 2'd0)      m_lfsr = {24'b0, seed[6:0]};
      else if (mode == 2'd1) m_lfsr = {16'b0, seed[14:0]};
      else                   m_lfsr = seed;
      if (m_lfsr == 31'd0) m_lfsr = 31'd1;
      m_prv = 1'b0;
      m_gen(m_cur);
      m_gen(m_nxt);
   endtask

   task automatic m_adv();
      m_prv = m_cur[P-1];
      m_cur = m_nxt;
      m_gen(m_nxt);
   endtask

   function automatic logic [P*6-1:0] m_dat(input bit flip0);
      logic [P*6-1:0] r;
      logic [P-1:0]   c;
      int             y, sp, sc, sn;
      c = m_cur;
      if (flip0) c[0] = ~c[0];
      r = '0;
      for (int k = 0; k < P; k++) begin
         sc = c[k] ? 1 : -1;
         if (k == 0) sp = m_prv ? 1 : -1;
         else        sp = c[k-1] ? 1 : -1;
         if (k == P-1) sn = m_nxt[0] ? 1 : -1;
         else          sn = c[k+1] ? 1 : -1;
         y = int'($signed(h0)) * sc + int'($signed(hm1)) * sn + int'($signed(hp1)) * sp;
         if (y > 31)  y = 31;
         if (y < -32) y = -32;
         r[k*6 +: 6] = y[5:0];
      end
      return r;
   endfunction

   task automatic run_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   task automatic stop_run();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      tick(); tick();
      checks++; if (be_if.o_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", be_if.o_vld); end
      checks++; if (be_if.o_dat !== '0) begin errors++; $display("FAIL reset_dat: got %h expected 0", be_if.o_dat); end
      checks++; if (be_if.o_bits_ref !== '0) begin errors++; $display("FAIL reset_bits: got %h expected 0", be_if.o_bits_ref); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (wcnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", wcnt); end
      start = 1'b0; rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_start_stop();
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_idle: busy got %b expected 0", busy); end
      tick();
   endtask

   task automatic test_prbs7();
      logic [3*P-1:0] cap;
      int             bad;
      mode = 2'd0; seed = 31'h7F; h0 = 6'd16; hm1 = 6'd0; hp1 = 6'd0;
      m_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prbs7_busy: got %b expected 1", busy); end
      checks++; if (be_if.o_vld !== 1'b0) begin errors++; $display("FAIL prbs7_vld_e0: got %b expected 0", be_if.o_vld); end
      tick(); tick();
      checks++; if (be_if.o_vld !== 1'b0) begin errors++; $display("FAIL prbs7_vld_e2: got %b expected 0", be_if.o_vld); end
      cap = '0;
      for (int j = 0; j < 20; j++) begin
         tick();
         checks++; if (be_if.o_vld !== 1'b1) begin errors++; $display("FAIL prbs7_vld w%0d: got %b expected 1", j, be_if.o_vld); end
         checks++; if (be_if.o_bits_ref !== m_cur) begin errors++; $display("FAIL prbs7_bits w%0d: got %h expected %h", j, be_if.o_bits_ref, m_cur); end
         checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL prbs7_dat w%0d: got %h expected %h", j, be_if.o_dat, m_dat(1'b0)); end
         checks++; if (wcnt !== CW'((j + 1 > 15) ? 15 : j + 1)) begin errors++; $display("FAIL prbs7_cnt w%0d: got %0d expected %0d", j, wcnt, (j + 1 > 15) ? 15 : j + 1); end
         if (j == 0) begin
            checks++; if (be_if.o_bits_ref[6:0] !== 7'b1000000) begin errors++; $display("FAIL prbs7_first_bits: got %b expected 1000000", be_if.o_bits_ref[6:0]); end
         end
         if (j < 3) cap[j*P +: P] = be_if.o_bits_ref;
         m_adv();
      end
      bad = 0;
      for (int i = 0; i < 65; i++) if (cap[i] !== cap[i+127]) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL prbs7_period127: got %0d differing bits expected 0", bad); end
      stop_run();
      checks++; if (be_if.o_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL prbs7_stop: got vld=%b busy=%b expected 0 0", be_if.o_vld, busy); end
   endtask

   task automatic test_pattern_zero();
      mode = 2'd3; pat = {32{2'b01}}; h0 = 6'd16; hm1 = 6'd8; hp1 = 6'd8;
      m_start();
      run_start();
      for (int j = 0; j < 4; j++) begin
         tick();
         checks++; if (be_if.o_vld !== 1'b1) begin errors++; $display("FAIL pat01_vld w%0d: got %b expected 1", j, be_if.o_vld); end
         checks++; if (be_if.o_dat !== '0) begin errors++; $display("FAIL pat01_dat w%0d: got %h expected 0", j, be_if.o_dat); end
         checks++; if (be_if.o_bits_ref !== pat) begin errors++; $display("FAIL pat01_bits w%0d: got %h expected %h", j, be_if.o_bits_ref, pat); end
      end
      stop_run();
   endtask

   task automatic test_saturation();
      logic [P*6-1:0] exp_hi, exp_lo;
      exp_hi = '0; exp_lo = '0;
      for (int k = 0; k < P; k++) begin
         exp_hi[k*6 +: 6] = 6'h1F;
         exp_lo[k*6 +: 6] = 6'h20;
      end
      mode = 2'd3; h0 = 6'd31; hm1 = 6'd31; hp1 = 6'd31;
      pat = '1;
      run_start();
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++; if (be_if.o_dat !== exp_hi) begin errors++; $display("FAIL sat_pos w%0d: got %h expected %h", j, be_if.o_dat, exp_hi); end
      end
      stop_run();
      pat = '0;
      run_start();
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++; if (be_if.o_dat !== exp_lo) begin errors++; $display("FAIL sat_neg w%0d: got %h expected %h", j, be_if.o_dat, exp_lo); end
      end
      stop_run();
   endtask

   task automatic test_seed0_prbs15();
      mode = 2'd1; seed = 31'd0; h0 = 6'd10; hm1 = 6'h3D; hp1 = 6'd5;
      m_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         checks++; if (be_if.o_vld !== 1'b0) begin errors++; $display("FAIL prbs15_vld_early c%0d: got %b expected 0", c, be_if.o_vld); end
         tick();
      end
      for (int j = 0; j < 6; j++) begin
         checks++; if (be_if.o_vld !== 1'b1) begin errors++; $display("FAIL prbs15_vld w%0d: got %b expected 1", j, be_if.o_vld); end
         checks++; if (be_if.o_bits_ref === '0) begin errors++; $display("FAIL prbs15_zero_word w%0d: got all-zero expected nonzero", j); end
         checks++; if (be_if.o_bits_ref !== m_cur) begin errors++; $display("FAIL prbs15_bits w%0d: got %h expected %h", j, be_if.o_bits_ref, m_cur); end
         checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL prbs15_dat w%0d: got %h expected %h", j, be_if.o_dat, m_dat(1'b0)); end
         if (j == 0) begin
            checks++; if (be_if.o_bits_ref[13:0] !== 14'h2000) begin errors++; $display("FAIL prbs15_first_bits: got %h expected 2000", be_if.o_bits_ref[13:0]); end
         end
         m_adv();
         tick();
      end
      stop_run();
   endtask

   task automatic test_en_freeze();
      logic [P-1:0]   held_b;
      logic [P*6-1:0] held_d;
      mode = 2'd2; seed = 31'h1234_5678; h0 = 6'd16; hm1 = 6'h3C; hp1 = 6'd6;
      m_start();
      run_start();
      held_b = '0; held_d = '0;
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++; if (be_if.o_bits_ref !== m_cur) begin errors++; $display("FAIL prbs31_bits w%0d: got %h expected %h", j, be_if.o_bits_ref, m_cur); end
         checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL prbs31_dat w%0d: got %h expected %h", j, be_if.o_dat, m_dat(1'b0)); end
         held_b = m_cur;
         held_d = m_dat(1'b0);
         m_adv();
      end
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (be_if.o_bits_ref !== held_b) begin errors++; $display("FAIL freeze_bits c%0d: got %h expected %h", c, be_if.o_bits_ref, held_b); end
         checks++; if (be_if.o_dat !== held_d) begin errors++; $display("FAIL freeze_dat c%0d: got %h expected %h", c, be_if.o_dat, held_d); end
         checks++; if (wcnt !== CW'(3) || be_if.o_vld !== 1'b1) begin errors++; $display("FAIL freeze_cnt_vld c%0d: got cnt=%0d vld=%b expected 3 1", c, wcnt, be_if.o_vld); end
      end
      en = 1'b1;
      tick();
      checks++; if (be_if.o_bits_ref !== m_cur) begin errors++; $display("FAIL resume_bits: got %h expected %h", be_if.o_bits_ref, m_cur); end
      checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL resume_dat: got %h expected %h", be_if.o_dat, m_dat(1'b0)); end
      checks++; if (wcnt !== CW'(4)) begin errors++; $display("FAIL resume_cnt: got %0d expected 4", wcnt); end
      stop_run();
   endtask

   task automatic test_rst_mid();
      mode = 2'd0; seed = 31'h5A; h0 = 6'd16; hm1 = 6'd0; hp1 = 6'd0;
      run_start();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (be_if.o_vld !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_vld_busy: got vld=%b busy=%b expected 0 0", be_if.o_vld, busy); end
      checks++; if (be_if.o_dat !== '0 || be_if.o_bits_ref !== '0) begin errors++; $display("FAIL rst_mid_data: got dat=%h bits=%h expected 0", be_if.o_dat, be_if.o_bits_ref); end
      checks++; if (wcnt !== '0) begin errors++; $display("FAIL rst_mid_cnt: got %0d expected 0", wcnt); end
      tick();
   endtask

   task automatic test_err_inj();
      mode = 2'd0; seed = 31'h55; h0 = 6'd16; hm1 = 6'd4; hp1 = 6'd4;
      m_start();
      run_start();
      tick();
      checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL inj_pre_dat: got %h expected %h", be_if.o_dat, m_dat(1'b0)); end
      m_adv();
      err_inj = 1'b1;
      tick();
      checks++; if (be_if.o_dat !== m_dat(INJ)) begin errors++; $display("FAIL inj_word_dat: got %h expected %h", be_if.o_dat, m_dat(INJ)); end
      checks++; if (be_if.o_bits_ref !== m_cur) begin errors++; $display("FAIL inj_word_bits: got %h expected %h", be_if.o_bits_ref, m_cur); end
      m_adv();
      tick();
      checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL inj_held_dat: got %h expected %h", be_if.o_dat, m_dat(1'b0)); end
      m_adv();
      err_inj = 1'b0;
      tick();
      checks++; if (be_if.o_dat !== m_dat(1'b0)) begin errors++; $display("FAIL inj_post_dat: got %h expected %h", be_if.o_dat, m_dat(1'b0)); end
      stop_run();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; err_inj = 1'b0;
      mode = 2'd0; seed = '0; pat = '0; h0 = '0; hm1 = '0; hp1 = '0;
      test_reset();
      test_idle_start_stop();
      test_prbs7();
      test_pattern_zero();
      test_saturation();
      test_seed0_prbs15();
      test_en_freeze();
      test_rst_mid();
      test_err_inj();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
